// File: rtl/baud_frac_gen.sv
// baud_frac_gen
// Fractional baud-rate tick generator. A down-counter produces one
// oversample tick (EN_Os) every div or div+1 clocks; a fraction
// accumulator decides which, so the average period is div + frac/2^FW.
// An oversample counter marks every OS-th tick as a bit tick (EN_Bit).
//
// Ports:
//   Clk, Reset    clock, synchronous active-high reset
//   Enable        run when high, freeze all counters when low
//   Load          strobe capturing Div_Int / Div_Frac / Os_Sel into the
//                 pending set (rejected when Div_Int == 0)
//   Div_Int       requested integer divisor
//   Div_Frac      requested fractional divisor (units of 1/2^C_FRAC_WIDTH)
//   Os_Sel        oversampling select: 00=16x, 01=8x, 10=4x, 11=16x
//   Resync        strobe restarting the phase, applying pending values now
//   EN_Os         registered one-cycle oversample tick
//   EN_Bit        registered one-cycle bit tick, coincident with EN_Os
//   Div_Err       registered sticky flag: last Load was rejected
//
// Handshake: there is no valid/ready pair here; Load and Resync are
// single-cycle strobes sampled on every rising Clk edge where Reset is low.
module baud_frac_gen #(
  parameter int C_DIV_WIDTH    = 16,
  parameter int C_FRAC_WIDTH   = 4,
  parameter int C_DEFAULT_DIV  = 48,
  parameter int C_DEFAULT_FRAC = 0
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic                    Load,
  input  logic [C_DIV_WIDTH-1:0]  Div_Int,
  input  logic [C_FRAC_WIDTH-1:0] Div_Frac,
  input  logic [1:0]              Os_Sel,
  input  logic                    Resync,
  output logic                    EN_Os,
  output logic                    EN_Bit,
  output logic                    Div_Err
);

  localparam logic [C_DIV_WIDTH-1:0]  DEF_DIV  = C_DIV_WIDTH'(C_DEFAULT_DIV);
  localparam logic [C_FRAC_WIDTH-1:0] DEF_FRAC = C_FRAC_WIDTH'(C_DEFAULT_FRAC);
  localparam logic [C_DIV_WIDTH-1:0]  ONE_DIV  = C_DIV_WIDTH'(1);

  // Last oversample index for a given select code (OS-1).
  function automatic logic [3:0] os_last(input logic [1:0] sel);
    case (sel)
      2'b01:   return 4'd7;
      2'b10:   return 4'd3;
      default: return 4'd15;
    endcase
  endfunction

  // Active and pending parameter sets; pend marks a pending set not yet
  // applied.
  logic [C_DIV_WIDTH-1:0]  div_a, div_p;
  logic [C_FRAC_WIDTH-1:0] frac_a, frac_p;
  logic [1:0]              os_a, os_p;
  logic                    pend;

  logic [C_DIV_WIDTH-1:0]  cnt;
  logic [C_FRAC_WIDTH-1:0] acc;
  logic [3:0]              osc;

  logic                    load_ok;
  logic                    reload;
  logic [C_DIV_WIDTH-1:0]  eff_div, rs_div, rs_cnt, reload_cnt;
  logic [C_FRAC_WIDTH-1:0] eff_frac, rs_frac;
  logic [1:0]              eff_os, rs_os;
  logic [C_FRAC_WIDTH:0]   acc_sum;
  logic                    os_change;
  logic                    bit_tick;

  always_comb begin
    load_ok    = Load && (Div_Int != '0);
    reload     = Enable && (cnt == '0);
    // The set that becomes active at the next restart point. A Load in
    // the same cycle as a reload only reaches the pending registers, so
    // it does not affect this reload.
    eff_div    = pend ? div_p  : div_a;
    eff_frac   = pend ? frac_p : frac_a;
    eff_os     = pend ? os_p   : os_a;
    // On Resync an accepted same-cycle Load takes effect immediately.
    rs_div     = load_ok ? Div_Int  : eff_div;
    rs_frac    = load_ok ? Div_Frac : eff_frac;
    rs_os      = load_ok ? Os_Sel   : eff_os;
    rs_cnt     = rs_div - ONE_DIV;
    acc_sum    = {1'b0, acc} + {1'b0, eff_frac};
    // Carry out of the fraction accumulator stretches this period by one.
    reload_cnt = eff_div - ONE_DIV + C_DIV_WIDTH'(acc_sum[C_FRAC_WIDTH]);
    // 00 and 11 are both 16x, so compare the decoded ratio, not the code.
    os_change  = os_last(eff_os) != os_last(os_a);
    bit_tick   = (osc == os_last(os_a));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_a   <= DEF_DIV;
      div_p   <= DEF_DIV;
      frac_a  <= DEF_FRAC;
      frac_p  <= DEF_FRAC;
      os_a    <= 2'b00;
      os_p    <= 2'b00;
      pend    <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      osc     <= '0;
      EN_Os   <= 1'b0;
      EN_Bit  <= 1'b0;
      Div_Err <= 1'b0;
    end else begin
      EN_Os  <= 1'b0;
      EN_Bit <= 1'b0;

      if (Resync) begin
        div_a  <= rs_div;
        frac_a <= rs_frac;
        os_a   <= rs_os;
        cnt    <= rs_cnt;
        acc    <= '0;
        osc    <= '0;
      end else if (reload) begin
        EN_Os  <= 1'b1;
        EN_Bit <= bit_tick;
        acc    <= acc_sum[C_FRAC_WIDTH-1:0];
        cnt    <= reload_cnt;
        div_a  <= eff_div;
        frac_a <= eff_frac;
        os_a   <= eff_os;
        if (os_change || bit_tick) begin
          osc <= '0;
        end else begin
          osc <= osc + 4'd1;
        end
      end else if (Enable) begin
        cnt <= cnt - ONE_DIV;
      end

      if (load_ok) begin
        div_p   <= Div_Int;
        frac_p  <= Div_Frac;
        os_p    <= Os_Sel;
        Div_Err <= 1'b0;
      end else if (Load) begin
        Div_Err <= 1'b1;
      end

      if (Resync) begin
        pend <= 1'b0;
      end else if (load_ok) begin
        pend <= 1'b1;
      end else if (reload) begin
        pend <= 1'b0;
      end
    end
  end

endmodule
